// File: rtl/eth_rx_frame_checker.sv
// eth_rx_frame_checker: frame-level Ethernet RX stage. Delimits frames by strobe gap,
// captures the MAC header, forwards the payload with the FCS stripped and reports
// CRC / length / address status in a one-cycle end-of-frame pulse.
module eth_rx_frame_checker #(
    parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned MIN_LEN    = 64,
    parameter int unsigned MAX_LEN    = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [7:0]  payload_o,
    output logic        payload_valid_o,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic        crc_err_o,
    output logic        len_err_o,
    output logic        addr_match_o,
    output logic [47:0] dst_mac_o,
    output logic [47:0] src_mac_o,
    output logic [15:0] ethertype_o,
    output logic [10:0] frame_len_o
);

    localparam int unsigned LEN_W     = 11;
    localparam int unsigned GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam int unsigned DST_END   = 6;
    localparam int unsigned SRC_END   = 12;
    localparam int unsigned ET_END    = 14;
    localparam int unsigned PAY_START = 18;

    localparam logic [LEN_W-1:0] LEN_SAT     = '1;
    localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [47:0]      BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_e;

    // Reflected CRC-32 update, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [31:0]      crc_q, crc_d;
    logic [3:0][7:0]  dly_q, dly_d;
    logic [47:0]      dst_q, dst_d;
    logic [47:0]      src_q, src_d;
    logic [15:0]      et_q, et_d;
    logic [7:0]       payload_q, payload_d;
    logic             payload_valid_q, payload_valid_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             crc_err_q, crc_err_d;
    logic             len_err_q, len_err_d;
    logic             addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [LEN_W-1:0] cur_idx;
    logic [31:0]      crc_base;
    logic             crc_bad;
    logic             len_bad;
    logic             addr_hit;

    // End-of-frame verdicts evaluated on the accumulated frame state.
    assign crc_bad  = (crc_q != CRC_RESIDUE);
    assign len_bad  = (idx_q < LEN_W'(MIN_LEN)) || (idx_q > LEN_W'(MAX_LEN));
    assign addr_hit = (dst_q == MAC_ADDR) || (dst_q == BCAST_ADDR);

    // Next-state logic: byte acceptance, header capture, FCS strip and gap timeout.
    always_comb begin
        state_d         = state_q;
        gap_d           = gap_q;
        idx_d           = idx_q;
        crc_d           = crc_q;
        dly_d           = dly_q;
        dst_d           = dst_q;
        src_d           = src_q;
        et_d            = et_q;
        payload_d       = payload_q;
        payload_valid_d = 1'b0;
        done_d          = 1'b0;
        ok_d            = ok_q;
        crc_err_d       = crc_err_q;
        len_err_d       = len_err_q;
        addr_d          = addr_q;
        len_d           = len_q;

        // A strobe seen in IDLE is byte 0 of a fresh frame.
        cur_idx  = (state_q == ST_RECV) ? idx_q : '0;
        crc_base = (state_q == ST_RECV) ? crc_q : CRC_INIT;

        if (byte_valid_i) begin
            state_d = ST_RECV;
            gap_d   = '0;
            idx_d   = (cur_idx == LEN_SAT) ? cur_idx : cur_idx + LEN_W'(1);
            crc_d   = crc32_byte(crc_base, byte_i);
            dly_d   = {dly_q[2:0], byte_i};

            if (cur_idx < LEN_W'(DST_END)) begin
                dst_d = {dst_q[39:0], byte_i};
            end else if (cur_idx < LEN_W'(SRC_END)) begin
                src_d = {src_q[39:0], byte_i};
            end else if (cur_idx < LEN_W'(ET_END)) begin
                et_d = {et_q[7:0], byte_i};
            end

            // Oldest delay-line entry is byte k-4; holding back 4 bytes drops the FCS.
            if (cur_idx >= LEN_W'(PAY_START)) begin
                payload_d       = dly_q[3];
                payload_valid_d = 1'b1;
            end
        end else if (state_q == ST_RECV) begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                state_d   = ST_IDLE;
                gap_d     = '0;
                done_d    = 1'b1;
                len_d     = idx_q;
                crc_err_d = crc_bad;
                len_err_d = len_bad;
                addr_d    = addr_hit;
                ok_d      = !crc_bad && !len_bad && addr_hit;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            gap_q           <= '0;
            idx_q           <= '0;
            crc_q           <= '0;
            dly_q           <= '0;
            dst_q           <= '0;
            src_q           <= '0;
            et_q            <= '0;
            payload_q       <= '0;
            payload_valid_q <= 1'b0;
            done_q          <= 1'b0;
            ok_q            <= 1'b0;
            crc_err_q       <= 1'b0;
            len_err_q       <= 1'b0;
            addr_q          <= 1'b0;
            len_q           <= '0;
        end else begin
            state_q         <= state_d;
            gap_q           <= gap_d;
            idx_q           <= idx_d;
            crc_q           <= crc_d;
            dly_q           <= dly_d;
            dst_q           <= dst_d;
            src_q           <= src_d;
            et_q            <= et_d;
            payload_q       <= payload_d;
            payload_valid_q <= payload_valid_d;
            done_q          <= done_d;
            ok_q            <= ok_d;
            crc_err_q       <= crc_err_d;
            len_err_q       <= len_err_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
        end
    end

    assign payload_o       = payload_q;
    assign payload_valid_o = payload_valid_q;
    assign frame_done_o    = done_q;
    assign frame_ok_o      = ok_q;
    assign crc_err_o       = crc_err_q;
    assign len_err_o       = len_err_q;
    assign addr_match_o    = addr_q;
    assign dst_mac_o       = dst_q;
    assign src_mac_o       = src_q;
    assign ethertype_o     = et_q;
    assign frame_len_o     = len_q;

endmodule
